// File: rtl/data_consuming_block_if.sv
// rtl/data_consuming_block_if.sv - 8-bit valid/ready byte stream between producer and consumer
interface data_consuming_block_if;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_in;

  modport master (
    output valid_in,
    output data_in,
    input  ready_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output ready_out
  );
endinterface

// File: rtl/data_consuming_block.sv
// rtl/data_consuming_block.sv - stream sink with rotating backpressure and incrementing-sequence checker
module data_consuming_block #(
  parameter logic [7:0] READY_PATTERN = 8'hFF,
  parameter int         CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  data_consuming_block_if.slave    stream,
  output logic                     locked,
  output logic [CNT_W-1:0]         beat_count,
  output logic [7:0]               err_count,
  output logic                     err_flag,
  output logic [7:0]               last_data
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pat_q;
  logic             ready_q;
  logic [7:0]       expected_q, expected_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [7:0]       err_q, err_d;
  logic             flag_q, flag_d;
  logic [7:0]       last_q, last_d;

  logic             accept;
  logic             seq_match;
  logic [7:0]       data_plus1;

  assign accept     = stream.valid_in && ready_q;
  assign seq_match  = (stream.data_in == expected_q);
  assign data_plus1 = stream.data_in + 8'd1;

  // Backpressure runs free of valid_in so the ready sequence has a fixed period of 8.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= READY_PATTERN;
      ready_q <= 1'b0;
    end else begin
      ready_q <= pat_q[0];
      pat_q   <= {pat_q[0], pat_q[7:1]};
    end
  end

  assign stream.ready_out = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (accept) state_d = LOCKED;
      LOCKED:   state_d = LOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // On a mismatch we resync to the received byte, so one dropped or repeated beat costs one error.
  always_comb begin
    expected_d = expected_q;
    beat_d     = beat_q;
    err_d      = err_q;
    flag_d     = flag_q;
    last_d     = last_q;
    if (accept) begin
      beat_d = beat_q + CNT_W'(1);
      last_d = stream.data_in;
      case (state_q)
        UNLOCKED: expected_d = data_plus1;
        LOCKED: begin
          if (seq_match) begin
            expected_d = expected_q + 8'd1;
          end else begin
            expected_d = data_plus1;
            flag_d     = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end
        default: expected_d = expected_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q <= 8'h00;
      beat_q     <= '0;
      err_q      <= 8'h00;
      flag_q     <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      expected_q <= expected_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      flag_q     <= flag_d;
      last_q     <= last_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign beat_count = beat_q;
  assign err_count  = err_q;
  assign err_flag   = flag_q;
  assign last_data  = last_q;

endmodule

// File: tb/tb_data_consuming_block.sv
// tb/tb_data_consuming_block.sv - scoreboard bench for data_consuming_block
module tb_data_consuming_block;

  localparam logic [7:0] PAT = 8'b1010_0110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked;
  logic [15:0] beat_count;
  logic [7:0]  err_count;
  logic        err_flag;
  logic [7:0]  last_data;

  data_consuming_block_if sif ();

  data_consuming_block #(
    .READY_PATTERN(PAT),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stream(sif),
    .locked(locked),
    .beat_count(beat_count),
    .err_count(err_count),
    .err_flag(err_flag),
    .last_data(last_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic [15:0] beat;
    logic [7:0]  err;
    logic        flag;
    logic [7:0]  last;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_bad = 0;

  logic        m_locked;
  logic [7:0]  m_exp;
  logic [7:0]  m_err;
  logic        m_flag;
  logic [15:0] m_beat;
  logic [7:0]  m_last;

  logic        acc_seen = 1'b0;
  int          hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent handshake observer feeding the monitor and the handshake tally.
  always @(posedge clk) begin
    acc_seen <= sif.valid_in && sif.ready_out && !rst;
    if (rst) hs_count <= 0;
    else if (sif.valid_in && sif.ready_out) hs_count <= hs_count + 1;
  end

  always @(negedge clk) begin
    if (acc_seen) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_empty: unexpected accepted beat, last_data %0h", last_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("beat_status", {29'd0, locked, beat_count, err_count, err_flag, last_data}, {29'd0, e});
      end
    end
  end

  task automatic model_reset();
    m_locked = 1'b0;
    m_exp    = 8'h00;
    m_err    = 8'h00;
    m_flag   = 1'b0;
    m_beat   = 16'h0;
    m_last   = 8'h00;
  endtask

  task automatic model_beat(input logic [7:0] d);
    if (!m_locked) begin
      m_locked = 1'b1;
      m_exp    = d + 8'd1;
    end else if (d == m_exp) begin
      m_exp = m_exp + 8'd1;
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      m_flag = 1'b1;
      m_exp  = d + 8'd1;
    end
    m_beat = m_beat + 16'd1;
    m_last = d;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_beat(input logic [7:0] d);
    int waited = 0;
    exp_t e;
    sif.valid_in = 1'b1;
    sif.data_in  = d;
    while (!sif.ready_out && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!sif.ready_out) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: ready_out %0b after %0d cycles, want 1", sif.ready_out, waited);
    end else begin
      model_beat(d);
      e = '{m_locked, m_beat, m_err, m_flag, m_last};
      sb_q.push_back(e);
    end
    @(negedge clk);
    sif.valid_in = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},  {63'd0, sif.ready_out}, 64'd0);
    chk({tag, "_locked"}, {63'd0, locked},        64'd0);
    chk({tag, "_beat"},   {48'd0, beat_count},    64'd0);
    chk({tag, "_err"},    {56'd0, err_count},     64'd0);
    chk({tag, "_flag"},   {63'd0, err_flag},      64'd0);
    chk({tag, "_last"},   {56'd0, last_data},     64'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sif.valid_in = 1'b0;
    sif.data_in  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    sb_q.delete();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic finish_test(input string tag);
    @(negedge clk);
    chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  logic [7:0] pat_v;
  logic [7:0] direct_v [6];
  int         ready_ones;

  initial begin
    sif.valid_in = 1'b0;
    sif.data_in  = 8'h00;
    model_reset();
    @(negedge clk);

    // Ready pattern from the first post-reset cycle, no traffic.
    do_reset();
    pat_v = PAT;
    ready_ones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("ready_pattern", {63'd0, sif.ready_out}, {63'd0, pat_v[i % 8]});
      if (sif.ready_out) ready_ones++;
    end
    chk("ready_ones", 64'(ready_ones), 64'd8);
    chk("idle_beat", {48'd0, beat_count}, 64'd0);

    // Producer-like stream 1,2,...,255,0,1,... under backpressure.
    do_reset();
    for (int i = 1; i <= 300; i++) drive_beat(8'(i));
    finish_test("prod");
    chk("prod_err",   {56'd0, err_count}, 64'd0);
    chk("prod_flag",  {63'd0, err_flag}, 64'd0);
    chk("prod_beat",  {48'd0, beat_count}, 64'd300);
    chk("prod_hs",    {48'd0, beat_count}, 64'(hs_count));
    chk("prod_last",  {56'd0, last_data}, 64'h2C);

    // Directed 10,11,12,20,21,21: two mismatches.
    do_reset();
    direct_v = '{8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd21};
    for (int i = 0; i < 6; i++) drive_beat(direct_v[i]);
    finish_test("dir");
    chk("dir_err",    {56'd0, err_count}, 64'd2);
    chk("dir_flag",   {63'd0, err_flag}, 64'd1);
    chk("dir_beat",   {48'd0, beat_count}, 64'd6);
    chk("dir_last",   {56'd0, last_data}, 64'd21);

    // Idle with pattern running leaves status untouched.
    repeat (20) @(negedge clk);
    chk("idle_beat6", {48'd0, beat_count}, 64'd6);
    chk("idle_lock",  {63'd0, locked}, 64'd1);
    chk("idle_last",  {56'd0, last_data}, 64'd21);

    // 300 zero beats: 299 mismatches, saturating at 255.
    do_reset();
    for (int i = 0; i < 300; i++) drive_beat(8'h00);
    finish_test("sat");
    chk("sat_err",  {56'd0, err_count}, 64'd255);
    chk("sat_flag", {63'd0, err_flag}, 64'd1);
    chk("sat_beat", {48'd0, beat_count}, 64'd300);

    // Reset coincident with an accepted beat, then relock cleanly.
    do_reset();
    for (int i = 1; i <= 5; i++) drive_beat(8'(i));
    finish_test("mid");
    chk("mid_beat5", {48'd0, beat_count}, 64'd5);
    begin
      int w = 0;
      while (!sif.ready_out && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    sif.valid_in = 1'b1;
    sif.data_in  = 8'd6;
    rst          = 1'b1;
    @(negedge clk);
    sif.valid_in = 1'b0;
    check_reset_values("midrst");
    rst = 1'b0;
    model_reset();
    drive_beat(8'd40);
    drive_beat(8'd41);
    finish_test("relock");
    chk("relock_lock", {63'd0, locked}, 64'd1);
    chk("relock_err",  {56'd0, err_count}, 64'd0);
    chk("relock_beat", {48'd0, beat_count}, 64'd2);
    chk("relock_last", {56'd0, last_data}, 64'd41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_consuming_block.md
# data_consuming_block

Sink-side endpoint and sequence checker for the 8-bit valid/ready stream emitted by the data-producing block. It drives `ready_out` from a programmable rotating backpressure pattern and accepts beats on `valid_in && ready_out`. Each accepted byte is checked against a modulo-256 incrementing sequence. It reports beat and error counts and a sticky error flag, and closes the loop in the stream test harness.

## Interface
Parameters:
- `READY_PATTERN`, default `8'hFF`: rotating ready mask. Bit 0 is used first. `8'hFF` means always ready.
- `CNT_W`, default `16`: width of `beat_count`.

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `valid_in`  input  1  producer beat valid
- `ready_out`  output  1  consumer ready (registered)
- `data_in`  input  8  producer data byte
- `locked`  output  1  first beat received; sequence tracking active
- `beat_count`  output  CNT_W  accepted beats, wraps modulo 2^CNT_W
- `err_count`  output  8  sequence mismatches, saturates at 255
- `err_flag`  output  1  sticky; set on first mismatch, cleared only by `rst`
- `last_data`  output  8  most recent accepted byte

## Operation
- Handshake: a beat is accepted in a cycle where `valid_in=1` and `ready_out=1` at the rising edge. With `ready_out=0`, `data_in`/`valid_in` are ignored. The producer holds them, so nothing is lost.
- Backpressure: an 8-bit register `pat` loads `READY_PATTERN` on reset. Every non-reset cycle: `ready_out <= pat[0]` and `pat <= {pat[0], pat[7:1]}` (rotate right). Period is 8 cycles regardless of `valid_in`.
- State machine with 2 states:
  - UNLOCKED, the reset state. On the first accepted beat: `expected <= data_in + 1` (8-bit wrap), go to LOCKED. No check is made on this beat.
  - LOCKED. On each accepted beat, compare `data_in` to `expected`.
    - Match: `expected <= expected + 1`.
    - Mismatch: increment `err_count` (saturating at 255), set `err_flag`, and resync with `expected <= data_in + 1`. A single dropped or duplicated beat therefore costs exactly one error.
  - LOCKED exits only via `rst`.
- Every accepted beat, including the locking beat: `beat_count <= beat_count + 1` (wraps), `last_data <= data_in`.
- Arithmetic: `expected` and `data_in + 1` are 8-bit, so `8'hFF` is followed by `8'h00` and this is not an error. `err_count` holds at `8'hFF`.

## Timing
- Reset values: `ready_out=0`, `locked=0`, `beat_count=0`, `err_count=0`, `err_flag=0`, `last_data=8'h00`, `pat=READY_PATTERN`, `expected=8'h00`, state UNLOCKED.
- `ready_out` first reflects `READY_PATTERN[0]` in the first cycle after `rst` deasserts, i.e. one clock of latency from `pat`.
- All status outputs are registered. They update in the cycle after the accepting edge, so latency is 1 clock.
- `locked` rises in the same update as the first `beat_count=1`.
- Reset mid-stream: reset wins over a simultaneous beat. The beat is dropped, all state is cleared, and relock happens on the next accepted beat with no error.
- Beat accepted in the same cycle that `err_count=255` is reached, or while it is already 255: `err_count` holds at 255 and `err_flag` stays 1.
- `valid_in=1` with `ready_out=0`: no state change other than the `pat` rotation.

## Test plan
- Connect to the producer with `READY_PATTERN=8'hFF`, run 300 cycles after reset.
  - Require `locked=1` and first `last_data=8'h01`.
  - Require clean `8'hFF`→`8'h00` wrap.
  - Require `err_count=0` and `beat_count` equal to the number of handshakes.
- `READY_PATTERN=8'b1010_0110` with the producer.
  - Require `ready_out` to repeat 0,1,1,0,0,1,0,1 from the first post-reset cycle.
  - Require zero errors over 500 cycles.
  - Require `beat_count` to equal the count of `ready_out=1` cycles with `valid_in=1`.
- Direct stimulus, always valid: 10, 11, 12, 20, 21, 21.
  - Require `err_count=2` and `err_flag=1`.
  - Require `beat_count=6` and `last_data=21`.
- 300 beats all `8'h00`: require `err_count` to saturate at 255 (299 mismatches) and `beat_count=300`.
- Assert `rst` in the same cycle as an accepted beat after 5 good beats.
  - Require all outputs at their reset values.
  - Then beats 40, 41 give `locked=1`, `err_count=0`, `beat_count=2`.
- `valid_in=0` for 20 cycles with the pattern running: require `beat_count`, `locked` and `last_data` unchanged.
